// File: rtl/puzzle2_range_feeder.sv
// puzzle2_range_feeder
//
// Front-end for the day-2 invalid-ID summing datapath. Parses an ASCII stream
// of comma-separated "lo-hi" decimal ranges, terminated by a newline, into
// unsigned WIDTH-bit bounds. Each valid range is handed to the range checker
// one at a time. Upstream bytes are back-pressured while a range is waiting.
//
// Ports:
//   clk          - single clock, all logic on the rising edge
//   reset        - synchronous, active-high reset
//   char_valid   - input byte valid
//   char_data    - ASCII input byte
//   char_ready   - feeder accepts a byte this cycle (decoded from state only)
//   range_ready  - checker accepts the presented range this cycle
//   wr_en        - range valid, held until accepted
//   id1 / id2    - range low / high bound
//   range_count  - ranges emitted since reset (wraps)
//   done         - sticky, input fully parsed and last range accepted
//   error        - sticky, malformed input or numeric overflow

module puzzle2_range_feeder #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             char_valid,
  input  logic [7:0]       char_data,
  output logic             char_ready,
  input  logic             range_ready,
  output logic             wr_en,
  output logic [WIDTH-1:0] id1,
  output logic [WIDTH-1:0] id2,
  output logic [CNT_W-1:0] range_count,
  output logic             done,
  output logic             error
);

  localparam logic [2:0] ST_LO   = 3'd0;
  localparam logic [2:0] ST_HI   = 3'd1;
  localparam logic [2:0] ST_EMIT = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  logic [2:0]       state;
  logic [WIDTH-1:0] acc;
  logic             seen;
  logic             last_comma;

  logic             take;
  logic             is_digit;
  logic             is_ignored;
  logic             is_term;
  logic [WIDTH+3:0] acc_ext;
  logic [WIDTH+3:0] acc_next;
  logic             overflow;

  // Byte classification and the decimal accumulate step. The multiply by ten
  // is done as two shifts at WIDTH+4 bits so any carry out of WIDTH bits is
  // visible as overflow rather than silently wrapping.
  always_comb begin
    is_digit   = (char_data >= 8'h30) && (char_data <= 8'h39);
    is_ignored = (char_data == CH_CR) || (char_data == CH_SPACE);
    is_term    = (char_data == CH_COMMA) || (char_data == CH_LF);
    acc_ext    = {4'b0000, acc};
    acc_next   = (acc_ext << 3) + (acc_ext << 1) + {{WIDTH{1'b0}}, char_data[3:0]};
    overflow   = |acc_next[WIDTH+3:WIDTH];
  end

  // Ready depends only on the state register (and is masked during reset) so
  // it never forms a combinational path from char_valid.
  assign char_ready = !reset && ((state == ST_LO) || (state == ST_HI));
  assign take       = char_valid && char_ready;

  // Main parser. LO and HI share the digit/whitespace handling; they differ
  // only in which separator they accept and what happens on it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_LO;
      acc         <= '0;
      seen        <= 1'b0;
      last_comma  <= 1'b0;
      wr_en       <= 1'b0;
      id1         <= '0;
      id2         <= '0;
      range_count <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      case (state)
        ST_LO, ST_HI: begin
          if (take) begin
            if (is_digit) begin
              if (overflow) begin
                state <= ST_ERR;
                error <= 1'b1;
              end else begin
                acc  <= acc_next[WIDTH-1:0];
                seen <= 1'b1;
              end
            end else if (is_ignored) begin
              state <= state;
            end else if (state == ST_LO) begin
              if ((char_data == CH_MINUS) && seen) begin
                id1   <= acc;
                acc   <= '0;
                seen  <= 1'b0;
                state <= ST_HI;
              end else if ((char_data == CH_LF) && !seen) begin
                // Empty line or trailing comma ends the input cleanly.
                state <= ST_DONE;
                done  <= 1'b1;
              end else begin
                state <= ST_ERR;
                error <= 1'b1;
              end
            end else begin
              if (is_term && seen) begin
                id2        <= acc;
                acc        <= '0;
                seen       <= 1'b0;
                last_comma <= (char_data == CH_COMMA);
                if (id1 <= acc) begin
                  state <= ST_EMIT;
                  wr_en <= 1'b1;
                end else if (char_data == CH_COMMA) begin
                  // Inverted range is dropped without a bubble.
                  state <= ST_LO;
                end else begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                end
              end else begin
                state <= ST_ERR;
                error <= 1'b1;
              end
            end
          end
        end

        ST_EMIT: begin
          if (range_ready) begin
            wr_en       <= 1'b0;
            range_count <= range_count + 1'b1;
            acc         <= '0;
            seen        <= 1'b0;
            if (last_comma) begin
              state <= ST_LO;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end

        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: doc/puzzle2_range_feeder.md
# puzzle2_range_feeder

Front-end for the day-2 invalid-ID summing datapath. It consumes the puzzle input as an ASCII byte stream of comma-separated `lo-hi` decimal ranges terminated by newline. It parses each range into 64-bit unsigned values and presents them one at a time on the `wr_en`/`id1`/`id2` interface that the range checker reads. It is the writer side of that interface: it applies backpressure upstream while a range waits for the checker.

## Interface

Parameters:
- `WIDTH`, 64: width of parsed IDs.
- `CNT_W`, 16: width of the emitted-range counter.

Ports:
- `clk`, in, 1: single clock; all logic on rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `char_valid`, in, 1: input byte valid.
- `char_data`, in, 8: ASCII byte.
- `char_ready`, out, 1: feeder accepts the byte this cycle.
- `range_ready`, in, 1: checker accepts the presented range this cycle.
- `wr_en`, out, 1: range valid; held until accepted.
- `id1`, out, WIDTH: range low bound.
- `id2`, out, WIDTH: range high bound.
- `range_count`, out, CNT_W: number of ranges emitted since reset; wraps modulo 2^CNT_W.
- `done`, out, 1: sticky; input fully parsed and last range accepted.
- `error`, out, 1: sticky; malformed input or overflow.

## Operation

- A byte transfers when `char_valid && char_ready`.
- A range transfers when `wr_en && range_ready`.
- States:
  - LO: accumulating the low bound.
  - HI: accumulating the high bound.
  - EMIT: presenting a range.
  - DONE: input fully parsed.
  - ERR: malformed input or overflow.
- Reset state is LO with accumulators cleared.
- `char_ready` = 1 in LO and HI; 0 in EMIT, DONE and ERR; forced 0 while `reset` is high.
- Digit `'0'..'9'`: `acc <= acc*10 + d`.
  - Compute `acc*10` as `(acc<<3)+(acc<<1)` at WIDTH+4 bits.
  - Any result above 2^WIDTH-1 goes to ERR.
  - Leading zeros are legal.
- `'\r'` and `' '` are ignored in LO and HI.
- In LO:
  - `'-'` with ≥1 digit seen: latch `lo`, go to HI.
  - `'\n'` with no digits seen (empty line or trailing comma): go to DONE, no emit.
  - Any other byte goes to ERR, including `'-'` with no digits, `','`, and `'\n'` after digits.
- In HI:
  - `','` or `'\n'` with ≥1 digit seen: latch `hi` and remember the terminator.
  - If `lo <= hi`, go to EMIT.
  - If `lo > hi`, drop the range silently: go to LO on `','`, DONE on `'\n'`.
  - `'-'`, a terminator with no digits, or any other byte goes to ERR.
- EMIT:
  - `wr_en`=1, `id1`=lo, `id2`=hi; values stable while waiting.
  - On acceptance: `range_count++`, clear accumulators, go to LO if the terminator was `','`, else DONE.
- DONE: `done`=1, `char_ready`=0; only reset exits.
- ERR: `error`=1, `wr_en`=0, `char_ready`=0; only reset exits. A range already in EMIT is never in ERR simultaneously.
- `range_ready` is ignored when `wr_en`=0.

## Timing

- Reset values: `wr_en`=0, `id1`=0, `id2`=0, `range_count`=0, `done`=0, `error`=0, `char_ready`=0 during reset and 1 the first cycle after.
- All outputs except `char_ready` are registered. `char_ready` is decoded from the state register only and never depends on `char_valid`.
- One byte per cycle maximum in LO/HI, no bubbles.
- Terminator accepted in cycle N → `wr_en`=1 in cycle N+1.
- If `range_ready`=1 in N+1, the next byte can be accepted in N+2, for a 1-cycle bubble per range.
- Dropped range (`lo > hi`): back in LO at N+1, no bubble.
- `done` rises the cycle after the final acceptance, or after the `'\n'` that ends a dropped or empty range.
- `error` rises the cycle after the offending byte.
- Reset asserted in any state, including mid-number or in EMIT with `wr_en` high: next cycle all state and outputs return to reset values and the partial range is discarded.

## Test plan

1. Stream `"11-22,95-115\n"`, `range_ready`=1 → two single-cycle `wr_en` transfers, (11,22) then (95,115); `range_count`=2; `done`=1; `error`=0.
2. `"1-2,3-4\n"` with `range_ready` low 5 cycles at each emit → `wr_en` held 6 cycles per range; `id1`/`id2` stable; `char_ready`=0 throughout; no byte lost; `range_count`=2.
3. `"18446744073709551615-18446744073709551615\n"` → emits (2^64-1, 2^64-1), `done`. After reset, `"18446744073709551616-1\n"` → `error`=1 the cycle after the final `'6'`, no `wr_en`.
4. `"-5\n"` → `error` after `'-'`. After reset, `"1a-2\n"` → `error` after `'a'`; `char_ready`=0 afterwards; `range_count`=0.
5. `"30-20,1-2,\n"` → only (1,2) emitted; `range_count`=1; `done`=1 via the empty final field.
6. `"12-3"` followed by reset, then `"4-5\r\n"` → exactly one emit, (4,5); `range_count`=1; `done`=1.
